// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: request/result handshake plus the shared ALU port bundle
// of the iterative multiplier. The master side is the pipeline/ALU
// environment. The slave side is the sequencer itself.
interface mul_sequencer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     start;
  logic [DATA_WIDTH-1:0]    op_a;
  logic [DATA_WIDTH-1:0]    op_b;
  logic                     abort;
  logic                     ready;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    result_lo;
  logic [DATA_WIDTH-1:0]    result_hi;
  logic [DATA_WIDTH-1:0]    alu_srca;
  logic [DATA_WIDTH-1:0]    alu_srcb;
  logic [OPCODE_LENGTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]    alu_result;

  modport master (
    output start, op_a, op_b, abort, alu_result,
    input  ready, busy, done, result_lo, result_hi, alu_srca, alu_srcb, alu_op
  );

  modport slave (
    input  start, op_a, op_b, abort, alu_result,
    output ready, busy, done, result_lo, result_hi, alu_srca, alu_srcb, alu_op
  );
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-add unsigned multiplier that borrows the execute-stage
// ALU for one ADD per iteration. It produces the full 2*DATA_WIDTH-bit product
// after DATA_WIDTH iterations.
// Optional feature: define MUL_ABORT_EN to let `abort` flush a running multiply.
// When MUL_ABORT_EN is undefined, `abort` is ignored.
module mul_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input logic            clk,
  input logic            reset,
  mul_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD   = OPCODE_LENGTH'(4'b0010);
  localparam logic [CNT_W-1:0]         LAST_ITER = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // An unsigned add overflowed exactly when the sum wrapped below the augend.
  function automatic logic add_carry(input logic [DATA_WIDTH-1:0] sum,
                                     input logic [DATA_WIDTH-1:0] augend);
    return (sum < augend);
  endfunction

  state_t                state_r;
  state_t                next_state_s;
  logic [DATA_WIDTH-1:0] m_r;
  logic [DATA_WIDTH-1:0] hi_r;
  logic [DATA_WIDTH-1:0] lo_r;
  logic [CNT_W-1:0]      count_r;
  logic                  ready_r;
  logic                  busy_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] result_lo_r;
  logic [DATA_WIDTH-1:0] result_hi_r;
  logic [DATA_WIDTH-1:0] hi_nxt_s;
  logic [DATA_WIDTH-1:0] lo_nxt_s;
  logic                  carry_s;
  logic                  last_iter_s;
  logic                  abort_req_s;

`ifdef MUL_ABORT_EN
  assign abort_req_s = bus.abort;
`else
  logic unused_abort_s;
  assign unused_abort_s = bus.abort;
  assign abort_req_s    = 1'b0;
`endif

  // One shift-add step: the ALU sum and its carry become HI, and its LSB shifts into LO.
  always_comb begin
    carry_s     = add_carry(bus.alu_result, hi_r);
    hi_nxt_s    = {carry_s, bus.alu_result[DATA_WIDTH-1:1]};
    lo_nxt_s    = {bus.alu_result[0], lo_r[DATA_WIDTH-1:1]};
    last_iter_s = (count_r == LAST_ITER);
  end

  // Drive the shared ALU with HI + (multiplier bit ? M : 0) while running, and with zeros otherwise.
  always_comb begin
    bus.alu_op   = ALU_ADD;
    bus.alu_srca = {DATA_WIDTH{1'b0}};
    bus.alu_srcb = {DATA_WIDTH{1'b0}};
    if (state_r == RUN) begin
      bus.alu_srca = hi_r;
      if (lo_r[0]) begin
        bus.alu_srcb = m_r;
      end else begin
        bus.alu_srcb = {DATA_WIDTH{1'b0}};
      end
    end else begin
      bus.alu_srca = {DATA_WIDTH{1'b0}};
      bus.alu_srcb = {DATA_WIDTH{1'b0}};
    end
  end

  // Next-state selection. In RUN, abort takes priority over finishing.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (abort_req_s) begin
          next_state_s = IDLE;
        end else if (last_iter_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand load on an accepted start, then one iteration per RUN cycle unless flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_r     <= {DATA_WIDTH{1'b0}};
      hi_r    <= {DATA_WIDTH{1'b0}};
      lo_r    <= {DATA_WIDTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            m_r     <= bus.op_a;
            hi_r    <= {DATA_WIDTH{1'b0}};
            lo_r    <= bus.op_b;
            count_r <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          if (next_state_s != IDLE) begin
            hi_r    <= hi_nxt_s;
            lo_r    <= lo_nxt_s;
            count_r <= count_r + CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status and results are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_lo_r <= {DATA_WIDTH{1'b0}};
      result_hi_r <= {DATA_WIDTH{1'b0}};
    end else begin
      ready_r <= (next_state_s == IDLE);
      busy_r  <= (next_state_s == RUN);
      done_r  <= (next_state_s == DONE);
      if ((state_r == RUN) && (next_state_s == DONE)) begin
        result_lo_r <= lo_nxt_s;
        result_hi_r <= hi_nxt_s;
      end
    end
  end

  assign bus.ready     = ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result_lo = result_lo_r;
  assign bus.result_hi = result_hi_r;
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative unsigned multiplier controller that time-shares the execute-stage ALU to form a full 2×DATA_WIDTH-bit product. Each iteration drives one ALU ADD and consumes its result, so multiply support needs no dedicated adder. Sits beside the ALU in the execute stage. While a multiply runs, the sequencer owns the ALU operand/opcode inputs and the pipeline stalls on `busy`.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU opcode width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request; accepted only when `ready`=1
- `op_a`  in  DATA_WIDTH  multiplicand, sampled on accepted `start`
- `op_b`  in  DATA_WIDTH  multiplier, sampled on accepted `start`
- `abort`  in  1  flush request (active only with MUL_ABORT_EN)
- `ready`  out  1  high in IDLE
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse, result valid
- `result_lo`  out  DATA_WIDTH  low product word
- `result_hi`  out  DATA_WIDTH  high product word
- `alu_srca`, `alu_srcb`  out  DATA_WIDTH  ALU operands
- `alu_op`  out  OPCODE_LENGTH  ALU operation
- `alu_result`  in  DATA_WIDTH  combinational ALU result

## Operation
- States:
  - IDLE → RUN on `start`. Latches M=`op_a`, HI=0, LO=`op_b`, count=0.
  - RUN → DONE after DATA_WIDTH iterations.
  - DONE → IDLE unconditionally.
- RUN iteration, per cycle:
  - Drive `alu_op`=4'b0010 (ADD), `alu_srca`=HI, `alu_srcb`=LO[0] ? M : 0.
  - Compute carry = (`alu_result` < HI), unsigned compare.
  - Register update: {HI,LO} ← {carry, `alu_result`, LO[DATA_WIDTH-1:1]}.
  - count increments.
- Counter width: $clog2(DATA_WIDTH)+1. Leave RUN when count reaches DATA_WIDTH-1 and the final iteration completes.
- Arithmetic: operands are unsigned; the result is the full product modulo 2^(2·DATA_WIDTH). The low word is also the correct RISC-V MUL result for signed operands.
- Outside RUN, drive `alu_op`=4'b0010 and `alu_srca`=`alu_srcb`=0.
- In DONE, copy HI/LO to `result_hi`/`result_lo` and assert `done`. The results hold until the next DONE; they are not cleared on `start`.
- Outputs: `ready`=(state==IDLE), `busy`=(state==RUN).
- Boundary cases:
  - `start` while not IDLE: ignored, no effect on the operation in progress.
  - `op_b`=0 or `op_a`=0: still a full DATA_WIDTH iterations; result 0.
  - `abort` in IDLE or DONE: no effect. In DONE, `done` still pulses.
  - `abort` and `start` in the same IDLE cycle: `start` is accepted.
  - `reset` mid-operation: immediately IDLE, no `done`, results cleared.

## Timing
- Reset values: state=IDLE, `ready`=1, `busy`=0, `done`=0, `result_lo`=0, `result_hi`=0. Internal M/HI/LO/count=0.
- Let edge E0 be the edge that samples `start`.
- `busy`=1 for the DATA_WIDTH cycles following E0.
- `done`=1 in the cycle after edge E0+DATA_WIDTH, i.e. cycle DATA_WIDTH+1 after acceptance. Latency is 33 cycles for DATA_WIDTH=32.
- `ready` returns to 1 the cycle after `done`. Back-to-back throughput is one multiply per DATA_WIDTH+2 cycles.
- The ALU path is combinational within one cycle. `alu_result` is sampled on the same edge that advances the iteration.

## Configuration
- `MUL_ABORT_EN` defined:
  - `abort`=1 while in RUN forces IDLE on the next edge.
  - No `done` is produced and `result_*` is unchanged.
  - `abort` on the final iteration wins over DONE.
- `MUL_ABORT_EN` undefined: the `abort` port is present but ignored. Every accepted multiply completes.

## Test plan
- Basic product: reset, then `op_a`=7, `op_b`=6, `start` → `done` at cycle 33; `result_lo`=42, `result_hi`=0; `busy` high for exactly 32 cycles.
- Maximum operands: `op_a`=`op_b`=0xFFFFFFFF → `result_hi`=0xFFFFFFFE, `result_lo`=0x00000001. Exercises the carry path.
- Carry into high word: `op_a`=0x80000000, `op_b`=2 → `result_hi`=1, `result_lo`=0. Also check ALU ports show ADD each RUN cycle, and zero operands outside RUN.
- Start while busy: start 3×5, then pulse `start` with 9×9 at cycle 10 → single `done` with `result_lo`=15. Only one `done` pulse appears.
- Abort (MUL_ABORT_EN): start 100×100, `abort` at cycle 10 → IDLE next cycle, no `done`, results still 15. Then 3×5 completes with 15 after 33 cycles. Abort on cycle 32 also gives no `done`.
- Reset mid-op: start 0x1234×0x10, assert `reset` at cycle 20 → all outputs at reset values immediately, `ready`=1. A following 2×2 yields `result_lo`=4.
